// File: rtl/fpadd_scheduler_if.sv
// Client request/response and adder-datapath signals of the shared FP32 adder scheduler.
// slave is the scheduler's view; master is the requesters plus the adder datapath.
interface fpadd_scheduler_if #(
  parameter int N = 4
);
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [32*N-1:0] rsp_data;
  logic [N-1:0]    rsp_ovf;
  logic [N-1:0]    rsp_ready;
  logic            add_valid;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic [31:0]     add_result;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, add_result,
    input  req_ready, rsp_valid, rsp_data, rsp_ovf, add_valid, add_a, add_b
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, add_result,
    output req_ready, rsp_valid, rsp_data, rsp_ovf, add_valid, add_a, add_b
  );
endinterface

// File: rtl/fpadd_scheduler.sv
// Round-robin scheduler sharing one fixed-latency FP32 adder among N requesters; issue one cycle after grant.
// Result is held per requester (rsp_valid LAT+2 cycles after grant); an unconsumed result stalls only its owner.
module fpadd_scheduler #(
  parameter int N   = 4,
  parameter int LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  fpadd_scheduler_if.slave  bus,
  output logic              busy
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = IW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t          state     [N];
  state_t          nextState [N];
  logic [IW-1:0]   rrPtr;
  logic            grantVld;
  logic [IW-1:0]   grantIdx;
  logic [SW-1:0]   scanIdx;
  logic [IW-1:0]   scanPick;

  // Stage 0 lines up with add_valid, stage LAT with add_result.
  logic [LAT:0]    tagVld;
  logic [IW-1:0]   tagIdx [LAT+1];
  logic            capVld;
  logic [IW-1:0]   capIdx;

  logic [32*N-1:0] rspData;
  logic [N-1:0]    rspOvf;

  assign capVld = tagVld[LAT];
  assign capIdx = tagIdx[LAT];

  always_comb begin
    grantVld = 1'b0;
    grantIdx = '0;
    scanIdx  = '0;
    scanPick = '0;
    for (int k = 0; k < N; k++) begin
      scanIdx = SW'(rrPtr) + SW'(k);
      if (scanIdx >= SW'(N)) begin
        scanIdx = scanIdx - SW'(N);
      end
      scanPick = scanIdx[IW-1:0];
      if (!grantVld && bus.req_valid[scanPick] && state[scanPick] == IDLE) begin
        grantVld = 1'b1;
        grantIdx = scanPick;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state[i] <= IDLE;
      end
    end else begin
      state <= nextState;
    end
  end

  // A requester cannot be granted while DONE, so release and reissue never share a cycle.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      nextState[i] = state[i];
      unique case (state[i])
        IDLE:     if (grantVld && grantIdx == IW'(i)) nextState[i] = INFLIGHT;
        INFLIGHT: if (capVld && capIdx == IW'(i))     nextState[i] = DONE;
        DONE:     if (bus.rsp_ready[i])               nextState[i] = IDLE;
        default:  nextState[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_ready[i] = (state[i] == IDLE);
      bus.rsp_valid[i] = (state[i] == DONE);
    end
  end

  assign busy         = ~&bus.req_ready;
  assign bus.rsp_data = rspData;
  assign bus.rsp_ovf  = rspOvf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr         <= '0;
      bus.add_valid <= 1'b0;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
      tagVld        <= '0;
      for (int k = 0; k <= LAT; k++) begin
        tagIdx[k] <= '0;
      end
      rspData       <= '0;
      rspOvf        <= '0;
    end else begin
      bus.add_valid <= grantVld;
      tagVld        <= {tagVld[LAT-1:0], grantVld};
      tagIdx[0]     <= grantIdx;
      for (int k = 1; k <= LAT; k++) begin
        tagIdx[k] <= tagIdx[k-1];
      end
      if (grantVld) begin
        rrPtr     <= (grantIdx == IW'(N-1)) ? '0 : grantIdx + IW'(1);
        bus.add_a <= bus.req_a[{grantIdx, 5'd0} +: 32];
        bus.add_b <= bus.req_b[{grantIdx, 5'd0} +: 32];
      end
      // Owner is INFLIGHT, so its holding register is free when the result lands.
      if (capVld) begin
        rspData[{capIdx, 5'd0} +: 32] <= bus.add_result;
        rspOvf[capIdx]                <= (bus.add_result[30:23] == 8'hFF);
      end
    end
  end
endmodule

// File: tb/tb_fpadd_scheduler.sv
// Bench for fpadd_scheduler: directed vectors, LAT-cycle adder stub, per-requester scoreboard queues.
module tb_fpadd_scheduler;
  localparam int N   = 4;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  fpadd_scheduler_if #(.N(N)) bus ();

  fpadd_scheduler #(.N(N), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [32:0] expQ [N][$];

  // Hand-computed operand/result table; index 4 overflows to +Inf.
  logic [31:0] vecA [5] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h40400000, 32'h7F7FFFFF};
  logic [31:0] vecB [5] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000, 32'h7F7FFFFF};
  logic [31:0] expR [5] = '{32'h40000000, 32'h40800000, 32'h3F800000, 32'h40C00000, 32'h7F800000};

  function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'hBF800000, 32'h40000000}: return 32'h3F800000;
      {32'h40400000, 32'h40400000}: return 32'h40C00000;
      {32'h7F7FFFFF, 32'h7F7FFFFF}: return 32'h7F800000;
      default:                      return 32'h0BAD0BAD;
    endcase
  endfunction

  logic [31:0] addPipe [LAT];
  always @(posedge clk) begin
    addPipe[0] <= bus.add_valid ? fpAdd(bus.add_a, bus.add_b) : 32'h0;
    for (int k = 1; k < LAT; k++) begin
      addPipe[k] <= addPipe[k-1];
    end
  end
  assign bus.add_result = addPipe[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input int v);
    bus.req_a[32*i +: 32] = vecA[v];
    bus.req_b[32*i +: 32] = vecB[v];
    bus.req_valid[i]      = 1'b1;
    expQ[i].push_back({(v == 4), expR[v]});
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check($sformatf("%s idle", name), busy, 0);
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          if (expQ[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected rsp%0d: data %0h with nothing pending", i, bus.rsp_data[32*i +: 32]);
          end else begin
            e = expQ[i].pop_front();
            check($sformatf("rsp%0d data", i), bus.rsp_data[32*i +: 32], e[31:0]);
            check($sformatf("rsp%0d ovf", i), bus.rsp_ovf[i], e[32]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic sawValid;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;
    #12;
    check("reset req_ready", bus.req_ready, 4'hF);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset add_valid", bus.add_valid, 0);
    check("reset add_a", bus.add_a, 0);
    check("reset busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Round robin from pointer 0, twice.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N; i++) setReq(i, i);
      for (int k = 0; k < N; k++) begin
        tick();
        check($sformatf("rr%0d grant%0d valid", pass, k), bus.add_valid, 1);
        check($sformatf("rr%0d grant%0d add_a", pass, k), bus.add_a, vecA[k]);
      end
      bus.req_valid = '0;
      waitIdle($sformatf("rr%0d", pass));
    end

    // Single op latency on requester 0.
    setReq(0, 0);
    tick();
    check("single add_valid", bus.add_valid, 1);
    check("single add_a", bus.add_a, 32'h3F800000);
    check("single add_b", bus.add_b, 32'h3F800000);
    check("single req_ready low", bus.req_ready[0], 0);
    bus.req_valid[0] = 1'b0;
    for (int c = 2; c <= LAT + 3; c++) begin
      tick();
      if (c == 2) check("single add_valid drop", bus.add_valid, 0);
      if (c <= LAT + 1) check($sformatf("single no rsp c%0d", c), bus.rsp_valid[0], 0);
      if (c == LAT + 2) begin
        check("single rsp_valid", bus.rsp_valid[0], 1);
        check("single rsp_data", bus.rsp_data[31:0], 32'h40000000);
        check("single rsp_ovf", bus.rsp_ovf[0], 0);
      end
      if (c == LAT + 3) check("single req_ready back", bus.req_ready[0], 1);
    end
    waitIdle("single");

    // Overflow on requester 2; pointer ends at 3.
    setReq(2, 4);
    tick();
    bus.req_valid[2] = 1'b0;
    n = 0;
    while (!bus.rsp_valid[2] && n < 20) begin
      tick();
      n++;
    end
    check("ovf rsp_valid", bus.rsp_valid[2], 1);
    check("ovf flag", bus.rsp_ovf[2], 1);
    check("ovf data", bus.rsp_data[95:64], 32'h7F800000);
    waitIdle("ovf");

    // Pointer wrap: 3 then 0, leaving pointer at 1.
    setReq(3, 3);
    setReq(0, 0);
    tick();
    check("wrap first", bus.add_a, 32'h40400000);
    tick();
    check("wrap second", bus.add_a, 32'h3F800000);
    bus.req_valid = '0;
    waitIdle("wrap");
    setReq(0, 1);
    setReq(1, 2);
    tick();
    check("ptr1 first is req1", bus.add_a, 32'hBF800000);
    tick();
    check("ptr1 second is req0", bus.add_a, 32'h40000000);
    bus.req_valid = '0;
    waitIdle("ptr1");

    // Backpressure on requester 1 while requester 0 keeps issuing.
    bus.rsp_ready[1] = 1'b0;
    setReq(1, 1);
    tick();
    bus.req_valid[1] = 1'b0;
    n = 0;
    while (!bus.rsp_valid[1] && n < 20) begin
      tick();
      n++;
    end
    check("bp rsp_valid rises", bus.rsp_valid[1], 1);
    setReq(0, 3);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) begin
        check("bp other issues", bus.add_valid, 1);
        check("bp other add_a", bus.add_a, 32'h40400000);
        bus.req_valid[0] = 1'b0;
      end
      check($sformatf("bp hold valid c%0d", c), bus.rsp_valid[1], 1);
      check($sformatf("bp hold data c%0d", c), bus.rsp_data[63:32], 32'h40800000);
      check($sformatf("bp req_ready c%0d", c), bus.req_ready[1], 0);
    end
    bus.rsp_ready[1] = 1'b1;
    tick();
    check("bp release idle", bus.req_ready[1], 1);
    waitIdle("bp");

    // Reset while requester 3's op is inside the adder.
    setReq(3, 0);
    tick();
    bus.req_valid[3] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst add_valid", bus.add_valid, 0);
    check("rst add_a", bus.add_a, 0);
    check("rst add_b", bus.add_b, 0);
    check("rst rsp_data", bus.rsp_data, 0);
    check("rst rsp_ovf", bus.rsp_ovf, 0);
    check("rst req_ready", bus.req_ready, 4'hF);
    check("rst busy", busy, 0);
    expQ[3].delete();
    @(negedge clk) rst_n = 1'b1;
    sawValid = 1'b0;
    for (int c = 0; c < LAT + 6; c++) begin
      tick();
      if (bus.rsp_valid != '0) sawValid = 1'b1;
    end
    check("rst dropped op silent", sawValid, 0);
    check("rst req_ready after", bus.req_ready, 4'hF);

    for (int i = 0; i < N; i++) begin
      check($sformatf("queue%0d drained", i), expQ[i].size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpadd_scheduler.md
Name: fpadd_scheduler

Overview:
Shares one fixed-latency FP32 adder pipeline (align -> ALU -> normalize) among N requesters. Each requester gets round-robin arbitration, at most one operation in flight, and a one-deep result holding register with valid/ready handshake. Returned results are steered using a tag shift register that matches the adder latency. Sits between client ports and the single adder datapath instance.

Parameters:
N, 4, number of requesters (2..8)
LAT, 3, adder latency in cycles from add_valid sampled to add_result valid (1..8)

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N  requester i has operands
req_a  in  32*N  operand A, slice [32i+31:32i], IEEE-754 single
req_b  in  32*N  operand B, same slicing
req_ready  out  N  requester i can issue (registered)
rsp_valid  out  N  result held for requester i
rsp_data  out  32*N  result for requester i
rsp_ovf  out  N  result exponent field == 8'hFF
rsp_ready  in  N  requester i consumes result
add_valid  out  1  operands presented to adder this cycle
add_a  out  32  operand A to adder
add_b  out  32  operand B to adder
add_result  in  32  adder output, valid exactly LAT cycles after add_valid
busy  out  1  any requester not IDLE

Behaviour:
- Reset (async, rst_n=0): all per-requester FSMs IDLE; req_ready = all ones; rsp_valid, rsp_ovf, rsp_data, add_valid, add_a, add_b = 0; tag pipeline cleared; RR pointer = 0; busy = 0. Reset mid-operation drops in-flight ops; results arriving after reset release are ignored because tag valids are cleared.
- Per-requester FSM: IDLE -> INFLIGHT on grant; INFLIGHT -> DONE when its tag exits the pipeline; DONE -> IDLE on rsp_valid && rsp_ready. req_ready[i] = (state==IDLE). rsp_valid[i] = (state==DONE).
- Arbitration: each cycle choose at most one i with req_valid[i] && req_ready[i]. Scan starts at RR pointer with wraparound. Winner index w: pointer <= (w+1) mod N. No winner: pointer unchanged.
- Issue: winner sampled at edge t. At t+1, add_valid=1, add_a/add_b = winner operands, and the tag pipeline stage 0 holds {valid, w}. add_valid=0 in cycles with no grant. Operands are registered; requester may change inputs after the handshake.
- Tag pipeline: LAT stages, shifts every cycle, no stall. When the last stage is valid with tag w, add_result is captured into rsp_data[w] at that edge, and rsp_ovf[w] = (add_result[30:23]==8'hFF). State(w) becomes DONE, so rsp_valid[w] rises the cycle after the result appears.
- Overflow: DONE is never blocked. A requester cannot reissue until its result is consumed, so its holding register is always empty when its result arrives.
- Backpressure: while DONE with rsp_ready=0, rsp_data and rsp_ovf stay stable and req_ready[i]=0.
- No same-cycle reissue: DONE->IDLE and grant of the same requester cannot occur in one cycle. Minimum gap between consecutive issues from one requester is LAT+3 cycles.
- Throughput: with N >= LAT+3 requesters saturating, one issue per cycle.
- Issue and capture at the same edge for different requesters are independent. A requester cannot be both issuing and capturing.
- busy = OR over i of (state_i != IDLE).

Test Plan:
- Single op: req 0 issues 0x3F800000 + 0x3F800000 at cycle 0 -> add_valid at cycle 1, rsp_valid[0] at cycle LAT+2, rsp_data=0x40000000, rsp_ovf=0; with rsp_ready=1, req_ready[0] returns at LAT+3.
- Round-robin: all 4 requesters valid at cycle 0 -> grants to 0,1,2,3 on consecutive cycles, add_a order matches. Re-raise all after completion with pointer at 0 -> order repeats 0,1,2,3.
- Overflow flag: 0x7F7FFFFF + 0x7F7FFFFF on req 2, adder model returns 0x7F800000 -> rsp_ovf[2]=1, rsp_data[2]=0x7F800000.
- Backpressure: hold rsp_ready[1]=0 for 10 cycles after result -> rsp_valid[1] and rsp_data[1] stable, req_ready[1]=0, other requesters keep issuing; release -> IDLE next cycle.
- Reset mid-flight: assert rst_n=0 one cycle after issue from req 3 -> all outputs 0 immediately (async). After release, no rsp_valid appears for the dropped op; req_ready = 4'b1111.
- Pointer wrap: only req 3 and req 0 valid with pointer=3 -> grant 3 then 0; pointer ends at 1.
